// File: rtl/text_banner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : text_banner                                                     |
// | Purpose  : Animated 4x5 block-font text overlay for the VGA pixel path.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module text_banner #(
    parameter int          NUM_CHARS     = 8,
    parameter int          H_ORIGIN      = 64,
    parameter int          V_ORIGIN      = 48,
    parameter int          SCALE_LOG2    = 4,
    parameter logic [11:0] FG_COLOR      = 12'hFFF,
    parameter logic [11:0] BG_COLOR      = 12'h000,
    parameter int          REVEAL_FRAMES = 8,
    parameter int          BLINK_FRAMES  = 30
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [9:0]             Hcount,
    input  logic [9:0]             Vcount,
    input  logic                   video_on,
    input  logic                   start,
    input  logic                   blink_en,
    input  logic [4*NUM_CHARS-1:0] msg,
    output logic [3:0]             red,
    output logic [3:0]             green,
    output logic [3:0]             blue,
    output logic                   revealed
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_REVEAL = 2'd1;
    localparam logic [1:0] c_SHOW   = 2'd2;

    localparam int c_FC_W = (REVEAL_FRAMES > 1) ? $clog2(REVEAL_FRAMES) : 1;
    localparam int c_BC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [c_FC_W-1:0] c_FC_LAST  = c_FC_W'(REVEAL_FRAMES - 1);
    localparam logic [c_FC_W-1:0] c_FC_ONE   = c_FC_W'(1);
    localparam logic [c_BC_W-1:0] c_BC_LAST  = c_BC_W'(BLINK_FRAMES - 1);
    localparam logic [c_BC_W-1:0] c_BC_ONE   = c_BC_W'(1);
    localparam logic [3:0]        c_NUM      = 4'(NUM_CHARS);
    localparam logic [9:0]        c_H0       = 10'(H_ORIGIN);
    localparam logic [9:0]        c_V0       = 10'(V_ORIGIN);
    localparam logic [9:0]        c_CX_LIMIT = 10'(5 * NUM_CHARS - 1);

    function automatic logic [19:0] glyph(input logic [3:0] code);
        logic [19:0] g;
        case (code)
            4'd0:    g = 20'h00000;
            4'd1:    g = 20'h69F99;
            4'd2:    g = 20'hF8E8F;
            4'd3:    g = 20'hF8B9F;
            4'd4:    g = 20'hE444E;
            4'd5:    g = 20'h8888F;
            4'd6:    g = 20'h9FF99;
            4'd7:    g = 20'h9DB99;
            4'd8:    g = 20'hF999F;
            4'd9:    g = 20'hE9E88;
            4'd10:   g = 20'hE9EA9;
            4'd11:   g = 20'hF8F1F;
            4'd12:   g = 20'hF4444;
            4'd13:   g = 20'h9999F;
            4'd14:   g = 20'h999A4;
            default: g = 20'h99FF9;
        endcase
        return g;
    endfunction

    // ------------------------------------------------------------------
    // Frame tick: one pulse per arrival at (0,0), however long it is held
    // ------------------------------------------------------------------
    logic w_at_origin;
    logic r_at_origin;
    logic r_tick;

    assign w_at_origin = (Hcount == 10'd0) && (Vcount == 10'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_at_origin <= 1'b0;
            r_tick      <= 1'b0;
        end else begin
            r_at_origin <= w_at_origin;
            r_tick      <= w_at_origin && !r_at_origin;
        end
    end

    // ------------------------------------------------------------------
    // Reveal state machine
    // ------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [4*NUM_CHARS-1:0] r_msg;
    logic [3:0]          r_shown;
    logic [c_FC_W-1:0]   r_frame_cnt;
    logic [c_BC_W-1:0]   r_blink_cnt;
    logic                r_phase;
    logic                w_show;
    logic                w_reveal;
    logic                w_reveal_step;
    logic                w_last_char;

    assign w_reveal_step = r_tick && (r_frame_cnt == c_FC_LAST);
    assign w_last_char   = ((r_shown + 4'd1) == c_NUM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (start) begin
            w_next_state = (NUM_CHARS == 1) ? c_SHOW : c_REVEAL;
        end else begin
            case (r_state)
                c_IDLE:   w_next_state = c_IDLE;
                c_REVEAL: if (w_reveal_step && w_last_char) w_next_state = c_SHOW;
                c_SHOW:   w_next_state = c_SHOW;
                default:  w_next_state = c_IDLE;
            endcase
        end
    end

    always_comb begin
        w_show   = (r_state == c_SHOW);
        w_reveal = (r_state == c_REVEAL);
        revealed = w_show;
    end

    // start outranks a coincident tick, so it is tested first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_msg       <= '0;
            r_shown     <= 4'd0;
            r_frame_cnt <= '0;
        end else if (start) begin
            r_msg       <= msg;
            r_shown     <= 4'd1;
            r_frame_cnt <= '0;
        end else if (w_reveal && r_tick) begin
            if (r_frame_cnt == c_FC_LAST) begin
                r_frame_cnt <= '0;
                r_shown     <= r_shown + 4'd1;
            end else begin
                r_frame_cnt <= r_frame_cnt + c_FC_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (w_show && blink_en && !start) begin
            if (r_tick) begin
                if (r_blink_cnt == c_BC_LAST) begin
                    r_blink_cnt <= '0;
                    r_phase     <= ~r_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + c_BC_ONE;
                end
            end
        end else begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: box test and cell coordinates
    // ------------------------------------------------------------------
    logic [9:0] w_dx;
    logic [9:0] w_dy;
    logic [9:0] w_cx;
    logic [9:0] w_cy;
    logic       w_in_box;
    logic       r_in_box;
    logic [5:0] r_cx;
    logic [2:0] r_cy;
    logic       r_vid;

    assign w_dx     = Hcount - c_H0;
    assign w_dy     = Vcount - c_V0;
    assign w_cx     = w_dx >> SCALE_LOG2;
    assign w_cy     = w_dy >> SCALE_LOG2;
    assign w_in_box = (Hcount >= c_H0) && (Vcount >= c_V0) &&
                      (w_cx < c_CX_LIMIT) && (w_cy < 10'd5);

    // Inside the box cx < 40 and cy < 5, so the narrow copies are exact
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_box <= 1'b0;
            r_cx     <= 6'd0;
            r_cy     <= 3'd0;
            r_vid    <= 1'b0;
        end else begin
            r_in_box <= w_in_box;
            r_cx     <= w_cx[5:0];
            r_cy     <= w_cy[2:0];
            r_vid    <= video_on;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: glyph lookup and colour
    // ------------------------------------------------------------------
    logic [5:0]  w_slot;
    logic [5:0]  w_col;
    logic [3:0]  w_code;
    logic [19:0] w_glyph;
    logic [3:0]  w_row;
    logic        w_bit;
    logic        w_visible;
    logic        w_blank;
    logic        w_fg;
    logic [11:0] w_color;

    assign w_slot  = r_cx / 6'd5;
    assign w_col   = r_cx % 6'd5;
    assign w_glyph = glyph(w_code);

    always_comb begin
        w_code = 4'd0;
        for (int i = 0; i < NUM_CHARS; i++) begin
            if (w_slot == 6'(i)) w_code = r_msg[4*i +: 4];
        end
    end

    always_comb begin
        case (r_cy)
            3'd0:    w_row = w_glyph[19:16];
            3'd1:    w_row = w_glyph[15:12];
            3'd2:    w_row = w_glyph[11:8];
            3'd3:    w_row = w_glyph[7:4];
            3'd4:    w_row = w_glyph[3:0];
            default: w_row = 4'd0;
        endcase
    end

    // blink_en gates the phase directly so dropping it restores FG at once
    assign w_bit     = w_row[2'd3 - w_col[1:0]];
    assign w_visible = w_show || ({2'b00, r_shown} > w_slot);
    assign w_blank   = r_phase && blink_en && w_show;
    assign w_fg      = r_in_box && (w_col != 6'd4) && w_visible && w_bit && !w_blank;
    assign w_color   = !r_vid ? 12'h000 : (w_fg ? FG_COLOR : BG_COLOR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red   <= 4'd0;
            green <= 4'd0;
            blue  <= 4'd0;
        end else begin
            {red, green, blue} <= w_color;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_text_banner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_text_banner                                                  |
// | Purpose  : Self-checking bench for text_banner (tables + reference model). |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_text_banner;

    localparam int          N   = 4;
    localparam int          HO  = 64;
    localparam int          VO  = 48;
    localparam int          SL  = 4;
    localparam int          RF  = 2;
    localparam int          BF  = 3;
    localparam logic [11:0] FG  = 12'hFFF;
    localparam logic [11:0] BG  = 12'h000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  Hcount = 10'd0;
    logic [9:0]  Vcount = 10'd0;
    logic        video_on = 1'b0;
    logic        start = 1'b0;
    logic        blink_en = 1'b0;
    logic [15:0] msg = 16'h2613;
    logic [3:0]  red, green, blue;
    logic        revealed;
    logic [11:0] rgb;

    assign rgb = {red, green, blue};

    text_banner #(
        .NUM_CHARS(N), .H_ORIGIN(HO), .V_ORIGIN(VO), .SCALE_LOG2(SL),
        .FG_COLOR(FG), .BG_COLOR(BG), .REVEAL_FRAMES(RF), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .Hcount(Hcount), .Vcount(Vcount),
        .video_on(video_on), .start(start), .blink_en(blink_en), .msg(msg),
        .red(red), .green(green), .blue(blue), .revealed(revealed)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [19:0] font [16] = '{20'h00000, 20'h69F99, 20'hF8E8F, 20'hF8B9F,
                               20'hE444E, 20'h8888F, 20'h9FF99, 20'h9DB99,
                               20'hF999F, 20'hE9E88, 20'hE9EA9, 20'hF8F1F,
                               20'hF4444, 20'h9999F, 20'h999A4, 20'h99FF9};

    // Reference model: time measured in ticks since start
    bit          m_started;
    int          m_ticks;
    int          m_blink;
    logic [15:0] m_msg;
    bit          m_prev_origin;
    bit          m_tick_pending;
    bit          p_vid;
    bit          p_hit;
    logic [11:0] last_rgb;

    function automatic int m_shown();
        int s;
        if (!m_started) return 0;
        s = 1 + m_ticks / RF;
        return (s > N) ? N : s;
    endfunction

    function automatic bit m_in_show();
        return m_started && (m_shown() == N);
    endfunction

    function automatic bit glyph_hit(input int h, input int v, input logic [15:0] mm, input int shown);
        int cx, cy, slot, col;
        logic [3:0]  code;
        logic [19:0] g;
        if (h < HO || v < VO) return 1'b0;
        cx = (h - HO) >> SL;
        cy = (v - VO) >> SL;
        if (cx >= 5 * N - 1 || cy >= 5) return 1'b0;
        slot = cx / 5;
        col  = cx % 5;
        if (col == 4 || slot >= shown) return 1'b0;
        code = mm[4*slot +: 4];
        g    = font[code];
        return g[19 - 4*cy - col];
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %03h expected %03h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started      = 1'b0;
        m_ticks        = 0;
        m_blink        = 0;
        m_msg          = 16'h0;
        m_prev_origin  = 1'b0;
        m_tick_pending = 1'b0;
        p_vid          = 1'b0;
        p_hit          = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // One clock of stimulus, with the model checking RGB and revealed every cycle
    task automatic drive(input int h, input int v, input bit vid, input bit st, input bit ben);
        bit          was_show, tick, ph;
        logic [11:0] exp;
        Hcount   = 10'(h);
        Vcount   = 10'(v);
        video_on = vid;
        start    = st;
        blink_en = ben;
        @(posedge clk);
        was_show = m_in_show();
        ph  = was_show && ben && (((m_blink / BF) % 2) == 1);
        exp = !p_vid ? 12'h000 : ((p_hit && !ph) ? FG : BG);
        tick = m_tick_pending;
        if (st) begin
            m_started = 1'b1;
            m_ticks   = 0;
            m_blink   = 0;
            m_msg     = msg;
        end else begin
            if (was_show && ben) begin
                if (tick) m_blink++;
            end else begin
                m_blink = 0;
            end
            if (tick && m_started && !was_show) m_ticks++;
        end
        m_tick_pending = (h == 0 && v == 0) && !m_prev_origin;
        m_prev_origin  = (h == 0 && v == 0);
        p_vid = vid;
        p_hit = glyph_hit(h, v, m_msg, m_shown());
        @(negedge clk);
        check("model_rgb", rgb, exp);
        check("model_revealed", {11'b0, revealed}, {11'b0, m_in_show()});
        last_rgb = rgb;
        start = 1'b0;
    endtask

    task automatic probe(input string name, input int h, input int v, input bit vid,
                         input bit ben, input logic [11:0] exp);
        for (int k = 0; k < 3; k++) drive(h, v, vid, 1'b0, ben);
        check(name, last_rgb, exp);
    endtask

    task automatic do_frame(input bit ben);
        drive(0, 0, 1'b0, 1'b0, ben);
        drive(10, 10, 1'b0, 1'b0, ben);
    endtask

    typedef struct {
        int          h;
        int          v;
        bit          vid;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl_a [8];
    vec_t tbl_b [11];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rnd_ben;
        tbl_a[0] = '{64, 48, 1'b1, 12'hFFF};
        tbl_a[1] = '{160, 48, 1'b1, 12'h000};
        tbl_a[2] = '{130, 50, 1'b1, 12'h000};
        tbl_a[3] = '{112, 48, 1'b1, 12'hFFF};
        tbl_a[4] = '{128, 48, 1'b1, 12'h000};
        tbl_a[5] = '{80, 64, 1'b1, 12'h000};
        tbl_a[6] = '{64, 64, 1'b1, 12'hFFF};
        tbl_a[7] = '{64, 48, 1'b0, 12'h000};

        tbl_b[0]  = '{144, 48, 1'b1, 12'h000};
        tbl_b[1]  = '{160, 48, 1'b1, 12'hFFF};
        tbl_b[2]  = '{224, 48, 1'b1, 12'hFFF};
        tbl_b[3]  = '{240, 48, 1'b1, 12'h000};
        tbl_b[4]  = '{304, 48, 1'b1, 12'hFFF};
        tbl_b[5]  = '{320, 48, 1'b1, 12'hFFF};
        tbl_b[6]  = '{368, 48, 1'b1, 12'h000};
        tbl_b[7]  = '{304, 112, 1'b1, 12'hFFF};
        tbl_b[8]  = '{304, 128, 1'b1, 12'h000};
        tbl_b[9]  = '{63, 48, 1'b1, 12'h000};
        tbl_b[10] = '{64, 47, 1'b1, 12'h000};

        model_reset();
        last_rgb = 12'h0;
        do_reset();

        // Idle after reset
        check("reset_revealed", {11'b0, revealed}, 12'h000);
        probe("idle_origin", 64, 48, 1'b1, 1'b0, 12'h000);
        probe("idle_vid_off", 64, 48, 1'b0, 1'b0, 12'h000);

        // Start, then sample before any tick
        msg = 16'h2613;
        drive(64, 48, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) probe($sformatf("tbl_a[%0d]", i), tbl_a[i].h, tbl_a[i].v,
                                          tbl_a[i].vid, 1'b0, tbl_a[i].exp);
        check("reveal_not_done", {11'b0, revealed}, 12'h000);

        // Five ticks: three slots shown, still revealing
        for (int i = 0; i < 5; i++) do_frame(1'b0);
        check("after5_revealed", {11'b0, revealed}, 12'h000);
        probe("after5_M", 224, 48, 1'b1, 1'b0, 12'hFFF);
        probe("after5_E_hidden", 304, 48, 1'b1, 1'b0, 12'h000);
        do_frame(1'b0);
        check("after6_revealed", {11'b0, revealed}, 12'h001);
        for (int i = 0; i < 11; i++) probe($sformatf("tbl_b[%0d]", i), tbl_b[i].h, tbl_b[i].v,
                                           tbl_b[i].vid, 1'b0, tbl_b[i].exp);

        // Two-clock latency
        for (int i = 0; i < 3; i++) drive(10, 10, 1'b1, 1'b0, 1'b0);
        drive(64, 48, 1'b1, 1'b0, 1'b0);
        check("lat_1clk", rgb, 12'h000);
        drive(10, 10, 1'b1, 1'b0, 1'b0);
        check("lat_2clk", rgb, 12'hFFF);
        drive(10, 10, 1'b1, 1'b0, 1'b0);
        check("lat_3clk", rgb, 12'h000);

        // Blink: phase flips every BF ticks, dropping blink_en restores at once
        for (int k = 1; k <= 4; k++) begin
            do_frame(1'b1);
            probe($sformatf("blink_k%0d", k), 64, 48, 1'b1, 1'b1,
                  (((k / BF) % 2) == 1) ? 12'h000 : 12'hFFF);
        end
        drive(64, 48, 1'b1, 1'b0, 1'b0);
        check("blink_drop", rgb, 12'hFFF);
        do_frame(1'b0);
        probe("blink_off_frame", 64, 48, 1'b1, 1'b0, 12'hFFF);

        // start coinciding with a tick: the tick is ignored
        drive(0, 0, 1'b0, 1'b0, 1'b0);
        drive(64, 48, 1'b1, 1'b1, 1'b0);
        probe("coinc_t0", 160, 48, 1'b1, 1'b0, 12'h000);
        do_frame(1'b0);
        probe("coinc_t1", 160, 48, 1'b1, 1'b0, 12'h000);
        do_frame(1'b0);
        probe("coinc_t2", 160, 48, 1'b1, 1'b0, 12'hFFF);

        // Asynchronous reset mid-reveal
        probe("pre_reset", 64, 48, 1'b1, 1'b0, 12'hFFF);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_rgb", rgb, 12'h000);
        check("async_rst_revealed", {11'b0, revealed}, 12'h000);
        do_reset();
        for (int i = 0; i < 3; i++) do_frame(1'b0);
        probe("post_reset_idle", 64, 48, 1'b1, 1'b0, 12'h000);
        check("post_reset_revealed", {11'b0, revealed}, 12'h000);

        // msg changes after start are ignored
        msg = 16'h2613;
        drive(64, 48, 1'b1, 1'b1, 1'b0);
        msg = 16'h0000;
        probe("msg_latched", 64, 48, 1'b1, 1'b0, 12'hFFF);

        // Randomized run against the model
        rnd_ben = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            int h, v;
            bit vid, st;
            if ($urandom_range(0, 39) == 0) begin
                h = 0;
                v = 0;
            end else begin
                h = $urandom_range(40, 400);
                v = $urandom_range(30, 140);
            end
            vid = ($urandom_range(0, 7) != 0);
            st  = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 49) == 0) rnd_ben = ~rnd_ben;
            if (st || $urandom_range(0, 99) == 0) msg = 16'($urandom);
            drive(h, v, vid, st, rnd_ben);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
